// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared constants and types for the SRAM port arbiter slice.
//   - ADDR_W_DEF / DATA_W_DEF : default geometry of the 1024x18 macro port
//   - MEM_RD_LAT              : edges from request accept to registered read data
//   - ST_IDLE / ST_CLEAR      : arbiter FSM state encodings
//   - sram_req_t              : one fabric-side request at default geometry
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 18;

  // Accept edge -> SRAM sample edge -> response register edge.
  localparam int MEM_RD_LAT = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wben;
    logic [DATA_W_DEF-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter. The grant is combinational from the
//   request vector; the "last granted" pointer only moves when a grant is
//   actually issued, so idle cycles do not disturb fairness.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req[1:0]     : request vector
//   i_advance      : permission to grant this cycle (0 forces no grant)
//   o_grant[1:0]   : one-hot grant, or zero
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // Index of the requester granted most recently. Resets to 1 so that
  // requester 0 wins the first contested cycle.
  logic r_lastGrant;

  // Grant selection: a lone requester always wins; on contention the
  // requester that was not served last time wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_advance) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_lastGrant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Pointer update on issued grants only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastGrant <= 1'b1;
    end else if (o_grant[0]) begin
      r_lastGrant <= 1'b0;
    end else if (o_grant[1]) begin
      r_lastGrant <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one port of a dual-port SRAM macro between two valid/ready
//   requesters (round-robin) and owns a clear engine that writes CLR_VALUE
//   to every word on command while holding the requesters off.
//   All mem_* outputs are registered; the macro uses active-low cen/wen and
//   a bit mask where 1 keeps the old bit.
// Ports
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_req_valid[1:0] / o_req_ready : per-requester handshake
//   i_req_we0/1, i_req_addr0/1     : 1=write / 0=read, word address
//   i_req_wben0/1, i_req_wdata0/1  : bit write enables (1=write), write data
//   o_rsp_valid[1:0], o_rsp_rdata  : one-cycle read response, per requester
//   i_clr_start                    : pulse to start a clear sweep
//   o_clr_busy, o_clr_done         : sweep in progress / final write issued
//   o_mem_cen, o_mem_wen           : SRAM enables (active-low)
//   o_mem_addr, o_mem_wmsk         : SRAM address, bit mask (1=keep)
//   o_mem_wdata, i_mem_rdata       : SRAM write / read data
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic              i_req_we0,
  input  logic              i_req_we1,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [DATA_W-1:0] i_req_wben0,
  input  logic [DATA_W-1:0] i_req_wben1,
  input  logic [DATA_W-1:0] i_req_wdata0,
  input  logic [DATA_W-1:0] i_req_wdata1,
  output logic [1:0]        o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_mem_cen,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wmsk,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The counter carries one spare bit so the terminal compare never aliases
  // with a wrapped address.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_clrAddr;
  logic              r_clrDone;

  logic              r_memCen;
  logic              r_memWen;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWmsk;
  logic [DATA_W-1:0] r_memWdata;

  logic [MEM_RD_LAT-1:0] r_pipeValid;
  logic [MEM_RD_LAT-1:0] r_pipeId;
  logic [1:0]            r_rspValid;
  logic [DATA_W-1:0]     r_rspRdata;

  logic              w_clrGo;
  logic              w_advance;
  logic [1:0]        w_grant;
  logic              w_anyGrant;
  logic              w_rdAccept;
  logic              w_selWe;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWben;
  logic [DATA_W-1:0] w_selWdata;
  logic              w_lastClr;

  // A clear request in IDLE takes priority over any pending request, so
  // arbitration is suppressed in that cycle as well as throughout CLEAR.
  assign w_clrGo   = (r_state == ST_IDLE) && i_clr_start;
  assign w_advance = (r_state == ST_IDLE) && !i_clr_start;
  assign w_lastClr = (r_clrAddr == LAST_ADDR);

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  assign w_anyGrant = |w_grant;
  assign w_rdAccept = w_anyGrant && !w_selWe;

  // Steer the granted requester's fields toward the SRAM registers.
  always_comb begin
    w_selWe    = i_req_we0;
    w_selAddr  = i_req_addr0;
    w_selWben  = i_req_wben0;
    w_selWdata = i_req_wdata0;
    if (w_grant[1]) begin
      w_selWe    = i_req_we1;
      w_selAddr  = i_req_addr1;
      w_selWben  = i_req_wben1;
      w_selWdata = i_req_wdata1;
    end
  end

  // FSM and clear sweep counter. The done pulse is raised on the same edge
  // that issues the final clear write, so it coincides with busy dropping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_clrAddr <= '0;
      r_clrDone <= 1'b0;
    end else begin
      r_clrDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_clrGo) begin
            r_state   <= ST_CLEAR;
            r_clrAddr <= '0;
          end
        end
        ST_CLEAR: begin
          r_clrAddr <= r_clrAddr + (ADDR_W + 1)'(1);
          if (w_lastClr) begin
            r_state   <= ST_IDLE;
            r_clrDone <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM command registers. Reads drive an all-ones mask so no bit can be
  // disturbed even if the macro honours the mask regardless of wen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_memCen   <= 1'b1;
      r_memWen   <= 1'b1;
      r_memAddr  <= '0;
      r_memWmsk  <= '0;
      r_memWdata <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_memCen   <= 1'b0;
      r_memWen   <= 1'b0;
      r_memAddr  <= r_clrAddr[ADDR_W-1:0];
      r_memWmsk  <= '0;
      r_memWdata <= CLR_VALUE;
    end else if (w_anyGrant) begin
      r_memCen   <= 1'b0;
      r_memWen   <= ~w_selWe;
      r_memAddr  <= w_selAddr;
      r_memWmsk  <= w_selWe ? ~w_selWben : '1;
      r_memWdata <= w_selWdata;
    end else begin
      r_memCen   <= 1'b1;
      r_memWen   <= 1'b1;
    end
  end

  // In-flight read tracker: stage 0 is loaded on the accept edge, the last
  // stage lines up with valid macro output. It runs independently of the
  // FSM so reads accepted just before a clear still return their data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipeValid <= '0;
      r_pipeId    <= '0;
      r_rspValid  <= 2'b00;
      r_rspRdata  <= '0;
    end else begin
      r_pipeValid <= {r_pipeValid[MEM_RD_LAT-2:0], w_rdAccept};
      r_pipeId    <= {r_pipeId[MEM_RD_LAT-2:0], w_grant[1]};
      r_rspValid  <= {r_pipeValid[MEM_RD_LAT-1] && r_pipeId[MEM_RD_LAT-1],
                      r_pipeValid[MEM_RD_LAT-1] && !r_pipeId[MEM_RD_LAT-1]};
      if (r_pipeValid[MEM_RD_LAT-1]) begin
        r_rspRdata <= i_mem_rdata;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_rdata = r_rspRdata;
  assign o_clr_busy  = (r_state == ST_CLEAR);
  assign o_clr_done  = r_clrDone;
  assign o_mem_cen   = r_memCen;
  assign o_mem_wen   = r_memWen;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wmsk  = r_memWmsk;
  assign o_mem_wdata = r_memWdata;

endmodule
